cnn_layer_scheduler: RTL and testbench

- Top-level sequencer for a CNN inference pass.
- Drives the memory-load, compute and display phases in order:
  - memory load then compute, repeated once per layer;
  - one display phase after the last layer.
- Each phase handshakes with a done input and runs under a per-phase timeout watchdog.
- Sits between host/start logic and the memory, compute and display engines; owns their enable lines.

---
 rtl/cnn_layer_scheduler.sv | 113 +++++++++++
 tb/tb_cnn_layer_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_scheduler.sv
// Top-level sequencer for one CNN inference pass: per-layer LOAD/COMPUTE,
// then DISPLAY, with a per-phase timeout watchdog and abort.
module cnn_layer_scheduler #(
  parameter int LAYER_W = 3,
  parameter int TO_W    = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] cfg_layers,
  input  logic               mem_done,
  input  logic               comp_done,
  input  logic               disp_done,
  output logic               enable_memory,
  output logic               enable_compute,
  output logic               enable_display,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DISPLAY = 3'd3,
    S_FINISH  = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [LAYER_W-1:0] count_q, count_d;
  logic [TO_W-1:0]    wd_q;
  logic               wd_exp;
  logic               active;

  assign active = (state_q == S_LOAD) || (state_q == S_COMPUTE) || (state_q == S_DISPLAY);
  assign wd_exp = (wd_q == TO_W'(TIMEOUT - 1));

  // Abort dominates; within a phase its done input beats the watchdog.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    count_d = count_q;
    if (abort) begin
      state_d = S_IDLE;
      layer_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state_d = S_LOAD;
            layer_d = '0;
            count_d = (cfg_layers == '0) ? LAYER_W'(1) : cfg_layers;
          end
        end
        S_LOAD: begin
          if (mem_done)    state_d = S_COMPUTE;
          else if (wd_exp) state_d = S_ERROR;
        end
        S_COMPUTE: begin
          if (comp_done) begin
            if (layer_q == count_q - LAYER_W'(1)) begin
              state_d = S_DISPLAY;
            end else begin
              state_d = S_LOAD;
              layer_d = layer_q + LAYER_W'(1);
            end
          end else if (wd_exp) begin
            state_d = S_ERROR;
          end
        end
        S_DISPLAY: begin
          if (disp_done)   state_d = S_FINISH;
          else if (wd_exp) state_d = S_ERROR;
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      count_q <= LAYER_W'(1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      count_q <= count_d;
      if (state_d != state_q || !active) wd_q <= '0;
      else                               wd_q <= wd_q + TO_W'(1);
    end
  end

  // Outputs decode the state register only, so reset clears them at once.
  assign enable_memory  = (state_q == S_LOAD);
  assign enable_compute = (state_q == S_COMPUTE);
  assign enable_display = (state_q == S_DISPLAY);
  assign busy           = active || (state_q == S_FINISH);
  assign done           = (state_q == S_FINISH);
  assign error          = (state_q == S_ERROR);
  assign layer_idx      = layer_q;
  assign state          = state_q;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Randomized pass-level bench for cnn_layer_scheduler: expectations come from
// per-pass phase lists (layers, phase lengths) rather than a cycle model.
module tb_cnn_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic [2:0] cfg_layers = '0;
  logic       mem_done = 1'b0, comp_done = 1'b0, disp_done = 1'b0;
  logic       enable_memory, enable_compute, enable_display;
  logic [2:0] layer_idx;
  logic       busy, done, error;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  cnn_layer_scheduler #(.LAYER_W(3), .TO_W(10), .TIMEOUT(1000)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_layers(cfg_layers),
    .mem_done(mem_done), .comp_done(comp_done), .disp_done(disp_done),
    .enable_memory(enable_memory), .enable_compute(enable_compute),
    .enable_display(enable_display), .layer_idx(layer_idx), .busy(busy),
    .done(done), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Enables must be one-hot-or-zero every cycle; also count done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot", 32'($countones({enable_memory, enable_compute, enable_display}) <= 1), 1);
      if (done) done_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic en_of(input int which);
    case (which)
      0:       return enable_memory;
      1:       return enable_compute;
      default: return enable_display;
    endcase
  endfunction

  // Enable for `which` is expected high now; answer its done after d extra
  // cycles, so the enable should be seen for exactly d+1 cycles. Optional
  // strays toggle the other done inputs and start, which must be ignored.
  task automatic phase(input int which, input int d, input bit strays);
    int n = 0;
    for (int i = 0; i <= d; i++) begin
      n += int'(en_of(which));
      mem_done  = (which == 0) ? (i == d) : (strays ? 1'($urandom) : 1'b0);
      comp_done = (which == 1) ? (i == d) : (strays ? 1'($urandom) : 1'b0);
      disp_done = (which == 2) ? (i == d) : (strays ? 1'($urandom) : 1'b0);
      start     = strays ? 1'($urandom) : 1'b0;
      step();
    end
    mem_done = 0; comp_done = 0; disp_done = 0; start = 0;
    chk($sformatf("phase%0d_len", which), n, d + 1);
  endtask

  task automatic kick(input logic [2:0] cfg);
    cfg_layers = cfg;
    start = 1;
    step();
    start = 0;
    cfg_layers = 3'($urandom);
  endtask

  task automatic run_pass(input logic [2:0] cfg, input bit strays, input int fixed_d);
    int nl = (cfg == 0) ? 1 : int'(cfg);
    int d0 = done_seen;
    kick(cfg);
    for (int l = 0; l < nl; l++) begin
      chk("load_en", enable_memory, 1);
      chk("load_idx", layer_idx, l);
      chk("load_busy", busy, 1);
      phase(0, (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 6)), strays);
      chk("comp_en", enable_compute, 1);
      chk("comp_idx", layer_idx, l);
      phase(1, (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 6)), strays);
    end
    chk("disp_en", enable_display, 1);
    chk("disp_state", state, 3);
    phase(2, (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 6)), strays);
    chk("fin_state", state, 4);
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 1);
    chk("fin_en", {enable_memory, enable_compute, enable_display}, 0);
    step();
    chk("idle_state", state, 0);
    chk("idle_done", done, 0);
    chk("held_idx", layer_idx, nl - 1);
    repeat (2) step();
    chk("done_once", done_seen - d0, 1);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_en", {enable_memory, enable_compute, enable_display}, 0);
    chk("rst_flags", {busy, done, error}, 0);
    chk("rst_idx", layer_idx, 0);
    @(negedge clk) rst = 0;
    step();

    // Basic pass: three layers, each done 5 cycles after its enable rises
    run_pass(3'd3, 1'b0, 5);
    // Zero layers behaves as one
    run_pass(3'd0, 1'b0, 2);

    // Randomized passes with stray inputs
    for (int k = 0; k < 25; k++)
      run_pass(3'($urandom_range(0, 7)), 1'($urandom), -1);

    // Timeout: never answer mem_done
    begin
      int n = 0;
      kick(3'd2);
      while (enable_memory && n < 1100) begin
        n++;
        step();
      end
      chk("to_len", n, 1000);
      chk("to_state", state, 5);
      chk("to_error", error, 1);
      chk("to_busy", busy, 0);
      chk("to_en", {enable_memory, enable_compute, enable_display}, 0);
      kick(3'd2);
      chk("restart_error", error, 0);
      chk("restart_state", state, 1);
      chk("restart_idx", layer_idx, 0);
      // Done in the last allowed cycle completes normally
      phase(0, 999, 1'b0);
      chk("late_done_state", state, 2);
      abort = 1; step(); abort = 0;
      chk("abort_clean", state, 0);
    end

    // Abort during layer 1 compute
    begin
      int d0;
      kick(3'd3);
      phase(0, 2, 1'b0);
      phase(1, 1, 1'b0);
      phase(0, 1, 1'b0);
      chk("ab_pre_state", state, 2);
      chk("ab_pre_idx", layer_idx, 1);
      repeat (2) step();
      d0 = done_seen;
      abort = 1; step(); abort = 0;
      chk("ab_en", {enable_memory, enable_compute, enable_display}, 0);
      chk("ab_state", state, 0);
      chk("ab_idx", layer_idx, 0);
      chk("ab_busy", busy, 0);
      repeat (20) step();
      chk("ab_no_done", done_seen - d0, 0);
    end

    // Done and abort on the same edge
    kick(3'd1);
    phase(0, 0, 1'b0);
    comp_done = 1; abort = 1; step(); comp_done = 0; abort = 0;
    chk("doneabort_state", state, 0);
    chk("doneabort_en", {enable_memory, enable_compute, enable_display}, 0);

    // Abort and start together in IDLE
    start = 1; abort = 1; cfg_layers = 3'd2; step(); start = 0; abort = 0;
    chk("startabort_state", state, 0);
    chk("startabort_busy", busy, 0);

    // comp_done held through LOAD
    kick(3'd1);
    comp_done = 1;
    repeat (3) step();
    chk("stray_load", state, 1);
    mem_done = 1; step(); mem_done = 0;
    chk("stray_comp", state, 2);
    step();
    comp_done = 0;
    chk("stray_disp", state, 3);
    phase(2, 0, 1'b0);
    step();
    chk("stray_idle", state, 0);

    // Async reset in DISPLAY
    kick(3'd1);
    phase(0, 0, 1'b0);
    phase(1, 0, 1'b0);
    chk("ar_pre", enable_display, 1);
    step();
    #2 rst = 1;
    #1;
    chk("ar_disp", enable_display, 0);
    chk("ar_state", state, 0);
    chk("ar_flags", {busy, done, error}, 0);
    chk("ar_idx", layer_idx, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    step();
    run_pass(3'd2, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
